// File: rtl/miriscv_irq_pkg.sv
// Shared types and constants for the miriscv interrupt controller.
package miriscv_irq_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FIN} irq_state_t;

  localparam int IRQ_NUM = 32;
  localparam logic [31:0] MCAUSE_IRQ_BIT = 32'h8000_0000;

endpackage

// File: rtl/miriscv_irq_prio_enc.sv
// Lowest-index-wins 32-to-5 encoder with a valid flag.
// Only instantiated when IRQ_CTRL_PRIORITY_EN is defined.
module miriscv_irq_prio_enc
  import miriscv_irq_pkg::*;
(
  input  logic [IRQ_NUM-1:0] req,
  output logic [4:0]         idx,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = IRQ_NUM - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx   = k[4:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller feeding the miriscv core: selects one enabled request,
// holds it until mret, then pulses int_fin. Macro IRQ_CTRL_PRIORITY_EN selects fixed priority.
module miriscv_irq_ctrl
  import miriscv_irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] int_req_i,
  input  logic [IRQ_NUM-1:0] mie_i,
  input  logic               int_rst_i,
  output logic               int_o,
  output logic [31:0]        mcause_o,
  output logic [IRQ_NUM-1:0] int_fin_o
);

  irq_state_t state;
  logic [4:0] idx;
  logic [4:0] sel_idx;
  logic       sel_valid;

`ifdef IRQ_CTRL_PRIORITY_EN
  miriscv_irq_prio_enc u_prio_enc (
    .req   (int_req_i & mie_i),
    .idx   (sel_idx),
    .valid (sel_valid)
  );
`else
  logic [4:0] cnt;

  // Round-robin: only the index under the scan pointer is considered each cycle.
  assign sel_idx   = cnt;
  assign sel_valid = int_req_i[cnt] & mie_i[cnt];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      int_o     <= 1'b0;
      mcause_o  <= '0;
      int_fin_o <= '0;
`ifndef IRQ_CTRL_PRIORITY_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          int_fin_o <= '0;
          if (sel_valid) begin
            idx      <= sel_idx;
            mcause_o <= MCAUSE_IRQ_BIT | {27'b0, sel_idx};
            int_o    <= 1'b1;
            state    <= BUSY;
          end
`ifndef IRQ_CTRL_PRIORITY_EN
          else begin
            cnt <= cnt + 5'd1;
          end
`endif
        end
        BUSY: begin
          if (int_rst_i) begin
            int_o     <= 1'b0;
            int_fin_o <= {{(IRQ_NUM-1){1'b0}}, 1'b1} << idx;
            state     <= FIN;
          end
        end
        FIN: begin
          int_fin_o <= '0;
          state     <= IDLE;
`ifndef IRQ_CTRL_PRIORITY_EN
          // Resume just past the served line so every requester gets a turn.
          cnt       <= idx + 5'd1;
`endif
        end
        default: begin
          int_o     <= 1'b0;
          int_fin_o <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Scoreboard bench for miriscv_irq_ctrl: a cycle model pushes expected outputs,
// popped and compared one edge later; directed latency checks on top.
module tb_miriscv_irq_ctrl;

`ifdef IRQ_CTRL_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] int_req;
  logic [31:0] mie;
  logic        int_rst;
  logic        int_o;
  logic [31:0] mcause_o;
  logic [31:0] int_fin_o;

  typedef struct packed {
    logic        irq;
    logic [31:0] mcause;
    logic [31:0] fin;
  } exp_t;

  exp_t exp_q[$];

  int n_checks;
  int n_errors;

  int          m_state;
  int          m_cnt;
  int          m_idx;
  logic        m_int;
  logic [31:0] m_mcause;
  logic [31:0] m_fin;

  miriscv_irq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .int_req_i (int_req),
    .mie_i     (mie),
    .int_rst_i (int_rst),
    .int_o     (int_o),
    .mcause_o  (mcause_o),
    .int_fin_o (int_fin_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_cnt    = 0;
    m_idx    = 0;
    m_int    = 1'b0;
    m_mcause = '0;
    m_fin    = '0;
  endtask

  task automatic model_step();
    logic [31:0] m;
    int          k;
    bit          hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m = int_req & mie;
    case (m_state)
      0: begin
        hit = 1'b0;
        k   = 0;
        if (PRIO) begin
          for (int j = 31; j >= 0; j--) if (m[j]) begin hit = 1'b1; k = j; end
        end else if (m[m_cnt]) begin
          hit = 1'b1;
          k   = m_cnt;
        end
        if (hit) begin
          m_idx    = k;
          m_state  = 1;
          m_int    = 1'b1;
          m_mcause = 32'h8000_0000 | k;
        end else if (!PRIO) begin
          m_cnt = (m_cnt + 1) % 32;
        end
      end
      1: if (int_rst) begin
        m_state = 2;
        m_int   = 1'b0;
        m_fin   = 32'h1 << m_idx;
      end
      default: begin
        m_fin   = '0;
        m_state = 0;
        if (!PRIO) m_cnt = (m_idx + 1) % 32;
      end
    endcase
  endtask

  // One clock: predict, push, advance, pop and compare.
  task automatic tick();
    exp_t e;
    model_step();
    exp_q.push_back('{irq: m_int, mcause: m_mcause, fin: m_fin});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("int_o", {31'b0, int_o}, {31'b0, e.irq});
    check_val("mcause_o", mcause_o, e.mcause);
    check_val("int_fin_o", int_fin_o, e.fin);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_int_o", {31'b0, int_o}, 32'h0);
    check_val("rst_mcause", mcause_o, 32'h0);
    check_val("rst_fin", int_fin_o, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_int(input int budget, output int n);
    n = 0;
    while (!int_o && n < budget) begin
      tick();
      n++;
    end
    if (!int_o) check_val("wait_int_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_rst();
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    int_req = int_req & ~m_fin;
  endtask

  int n;
  int seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    int_req  = '0;
    mie      = '0;
    int_rst  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // 1: single request at index 5
    mie     = 32'hFFFF_FFFF;
    int_req = 32'h0000_0020;
    do_reset();
    wait_int(64, n);
    check_val("t1_latency", n, PRIO ? 1 : 6);
    check_val("t1_mcause", mcause_o, 32'h8000_0005);
    int_req = '0;
    mie     = '0;
    repeat (3) tick();
    check_val("t1_hold_mcause", mcause_o, 32'h8000_0005);
    int_rst = 1'b1;
    tick();
    int_rst = 1'b0;
    check_val("t1_fin", int_fin_o, 32'h0000_0020);
    check_val("t1_int_low", {31'b0, int_o}, 32'h0);
    tick();
    check_val("t1_fin_one_cycle", int_fin_o, 32'h0);

    // 2: masked request never served, stray int_rst ignored
    mie     = 32'hFFFF_FFF7;
    int_req = 32'h0000_0008;
    seen    = 0;
    for (int c = 0; c < 100; c++) begin
      int_rst = (c == 50);
      tick();
      if (int_o || int_fin_o != 0) seen++;
    end
    int_rst = 1'b0;
    check_val("t2_no_activity", seen, 0);

    // 3: indices 3 and 5 together from cnt=0
    mie     = 32'hFFFF_FFFF;
    int_req = 32'h0000_0028;
    do_reset();
    wait_int(64, n);
    check_val("t3_first_latency", n, PRIO ? 1 : 4);
    check_val("t3_first_mcause", mcause_o, 32'h8000_0003);
    pulse_rst();
    wait_int(64, n);
    check_val("t3_second_latency", n, PRIO ? 2 : 3);
    check_val("t3_second_mcause", mcause_o, 32'h8000_0005);
    int_req = '0;
    pulse_rst();
    tick();

    // 4: index 31 then wrap to pending index 0
    int_req = 32'h8000_0000;
    do_reset();
    wait_int(64, n);
    check_val("t4_first_latency", n, PRIO ? 1 : 32);
    check_val("t4_first_mcause", mcause_o, 32'h8000_001F);
    int_req = 32'h0000_0001;
    pulse_rst();
    wait_int(64, n);
    check_val("t4_wrap_latency", n, 2);
    check_val("t4_wrap_mcause", mcause_o, 32'h8000_0000);
    int_req = '0;
    pulse_rst();
    tick();

    // 5: async reset while serving index 2
    int_req = 32'h0000_0004;
    do_reset();
    wait_int(64, n);
    check_val("t5_mcause", mcause_o, 32'h8000_0002);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("t5_rst_int_o", {31'b0, int_o}, 32'h0);
    check_val("t5_rst_mcause", mcause_o, 32'h0);
    check_val("t5_rst_fin", int_fin_o, 32'h0);
    tick();
    int_req = '0;
    rst_n   = 1'b1;
    seen    = 0;
    for (int c = 0; c < 40; c++) begin
      int_rst = (c == 5);
      tick();
      if (int_fin_o != 0) seen++;
    end
    int_rst = 1'b0;
    check_val("t5_no_fin", seen, 0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ((c % 20) == 0) begin
        int_req = $urandom;
        mie     = $urandom;
      end
      int_rst = ($urandom_range(0, 7) == 0);
      tick();
    end
    int_rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
